// File: rtl/func_key_menu.sv
// Two-button menu controller: "next" cycles the selected function, "ok" fires it
// with short/long press detection and a per-function hold level.
module func_key_menu #(
  parameter int unsigned NUM_FUNC    = 4,
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned LONG_CYCLES = 50000000,
  localparam int unsigned FUNC_W     = $clog2(NUM_FUNC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                next_key,
  input  logic                ok_key,
  output logic [FUNC_W-1:0]   func_sel,
  output logic [NUM_FUNC-1:0] trig_short,
  output logic [NUM_FUNC-1:0] trig_long,
  output logic [NUM_FUNC-1:0] func_hold,
  output logic                busy
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
  localparam int unsigned K_NEXT = 0;
  localparam int unsigned K_OK   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG
  } state_e;

  logic [1:0]          raw_keys;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          db_q, db_d;
  logic [DB_W-1:0]     db_cnt_q [2];
  logic [DB_W-1:0]     db_cnt_d [2];
  logic                next_press_q, next_press_d;
  logic                ok_press_q, ok_press_d;
  logic                ok_rel_q, ok_rel_d;
  state_e              state_q, state_d;
  logic [FUNC_W-1:0]   sel_q, sel_d;
  logic [FUNC_W-1:0]   sel_lat_q, sel_lat_d;
  logic [LONG_W-1:0]   long_cnt_q, long_cnt_d;
  logic [NUM_FUNC-1:0] trig_short_q, trig_short_d;
  logic [NUM_FUNC-1:0] trig_long_q, trig_long_d;
  logic [NUM_FUNC-1:0] hold_q, hold_d;
  logic                busy_q, busy_d;
  logic [NUM_FUNC-1:0] lat_onehot;

  assign raw_keys   = {ok_key, next_key};
  assign lat_onehot = NUM_FUNC'(1) << sel_lat_q;

  // Debounce: accept a new level only after DB_CYCLES consecutive differing samples
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      db_d[k]     = db_q[k];
      db_cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (db_cnt_q[k] == DB_W'(DB_CYCLES - 1)) begin
          db_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
    next_press_d = db_q[K_NEXT] & ~db_d[K_NEXT];
    ok_press_d   = db_q[K_OK] & ~db_d[K_OK];
    ok_rel_d     = ~db_q[K_OK] & db_d[K_OK];
  end

  // Ok FSM, selection stepping and registered outputs
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_lat_d    = sel_lat_q;
    long_cnt_d   = long_cnt_q;
    trig_short_d = '0;
    trig_long_d  = '0;
    busy_d       = (state_q != S_IDLE);
    hold_d       = (state_q != S_IDLE) ? lat_onehot : '0;

    if (next_press_q && (state_q == S_IDLE) && !ok_press_q) begin
      sel_d = (sel_q == FUNC_W'(NUM_FUNC - 1)) ? '0 : sel_q + FUNC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (ok_press_q) begin
          sel_lat_d  = sel_q;
          long_cnt_d = '0;
          state_d    = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (long_cnt_q != LONG_W'(LONG_CYCLES)) begin
          long_cnt_d = long_cnt_q + LONG_W'(1);
        end
        // Release takes priority over a coincident long-press terminal count
        if (ok_rel_q) begin
          trig_short_d = lat_onehot;
          state_d      = S_IDLE;
        end else if (long_cnt_q == LONG_W'(LONG_CYCLES - 1)) begin
          trig_long_d = lat_onehot;
          state_d     = S_LONG;
        end
      end
      S_LONG: begin
        if (ok_rel_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      db_q         <= '1;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
      next_press_q <= 1'b0;
      ok_press_q   <= 1'b0;
      ok_rel_q     <= 1'b0;
      state_q      <= S_IDLE;
      sel_q        <= '0;
      sel_lat_q    <= '0;
      long_cnt_q   <= '0;
      trig_short_q <= '0;
      trig_long_q  <= '0;
      hold_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= raw_keys;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      next_press_q <= next_press_d;
      ok_press_q   <= ok_press_d;
      ok_rel_q     <= ok_rel_d;
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_lat_q    <= sel_lat_d;
      long_cnt_q   <= long_cnt_d;
      trig_short_q <= trig_short_d;
      trig_long_q  <= trig_long_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
    end
  end

  assign func_sel   = sel_q;
  assign trig_short = trig_short_q;
  assign trig_long  = trig_long_q;
  assign func_hold  = hold_q;
  assign busy       = busy_q;

endmodule

// File: doc/func_key_menu.md
Name: func_key_menu

Overview:
Two-button menu controller that selects one of NUM_FUNC functions with a "next" key and fires it with an "ok" key.
- Distinguishes short and long ok presses.
- Provides a per-function hold level.
- Debounce, synchronisation and edge detection all run in one clock domain.
- Sits between the board push-buttons and the system control logic (reset request, save/output data triggers, mode switches). It replaces the fixed 3-function key block with a parametrised, mode-rich version.

Parameters:
NUM_FUNC, 4, number of selectable functions (2..16, need not be a power of 2)
DB_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz)
LONG_CYCLES, 50000000, ok-held cycles after the debounced press at which a long press is declared (1 s at 50 MHz)
FUNC_W, $clog2(NUM_FUNC), width of the selection index (derived; not to be overridden)

Ports:
clk  in  1  single clock; all logic is in this domain
rst_n  in  1  synchronous reset, active-low, sampled on rising clk
next_key  in  1  raw push-button, active-low, asynchronous to clk
ok_key  in  1  raw push-button, active-low, asynchronous to clk
func_sel  out  FUNC_W  currently selected function index (drive to LEDs)
trig_short  out  NUM_FUNC  one-hot, 1-cycle pulse on short ok press of the latched function
trig_long  out  NUM_FUNC  one-hot, 1-cycle pulse when ok is held LONG_CYCLES
func_hold  out  NUM_FUNC  one-hot level, high while ok is held (debounced) for the latched function
busy  out  1  high while the ok FSM is not IDLE (selection locked)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sync flops and debounced states go to 1 (released); debounce and long counters go to 0.
  - func_sel=0, FSM=IDLE.
  - trig_short=0, trig_long=0, func_hold=0, busy=0.
- Synchroniser: 2-flop per key, and no logic reads the raw key.
- Debounce, per key:
  - Counter increments while the synced level differs from the debounced state, and clears to 0 whenever they are equal.
  - When the counter reaches DB_CYCLES-1, the debounced state takes the synced level and the counter clears.
  - Glitches shorter than DB_CYCLES produce no change.
- Press event = debounced 1->0; release event = debounced 0->1. Each is one cycle wide, registered.
- Next key:
  - On a press event with FSM=IDLE, func_sel increments.
  - At NUM_FUNC-1 it wraps to 0, so non-power-of-2 codes are never produced.
  - The next press is ignored when FSM≠IDLE, or when an ok press event occurs in the same cycle (ok wins).
  - The release event of next has no effect.
- Ok FSM, states IDLE, PRESSED, LONG:
  - IDLE: on an ok press event, latch sel_lat<=func_sel, clear long_cnt, go to PRESSED.
  - PRESSED: long_cnt increments each cycle.
    - On an ok release event, go to IDLE; trig_short[sel_lat]=1 for the next cycle only.
    - Else, when long_cnt==LONG_CYCLES-1, trig_long[sel_lat]=1 for the next cycle only and go to LONG.
    - If the release event and long_cnt==LONG_CYCLES-1 coincide, release wins: short pulse, no long pulse.
  - LONG: on an ok release event, go to IDLE with no pulse.
- Output timing and sizing:
  - func_hold[sel_lat]=1 and busy=1 in PRESSED and LONG; both are registered and deassert the cycle after the FSM returns to IDLE.
  - Trigger latency: pulse asserts 1 clk after the registered release event, or after long_cnt hits its terminal value.
  - Trigger outputs are registered and never have more than one bit set; they never assert in consecutive cycles for one press.
  - long_cnt width is $clog2(LONG_CYCLES+1). It saturates and does not wrap; it is only compared in PRESSED.
- Mid-operation events:
  - rst_n low mid-press: everything returns to reset values.
  - If ok is still physically held after reset, the debounced state goes 1->0 after DB_CYCLES and counts as a fresh press. This is intended.
  - A func_sel change during a press is impossible (locked); sel_lat guarantees the triggered index equals the selection at press time.

Test Plan:
(Sim parameters: NUM_FUNC=3, DB_CYCLES=4, LONG_CYCLES=16.)
1. Hold rst_n=0 for 3 clks with both keys low -> func_sel=0, all trig/hold=0, busy=0. Release rst_n -> after 2 sync + 4 DB clks, busy=1 and func_hold=3'b001.
2. Pulse next_key low for 3 clks (under DB) five times, spaced apart -> func_sel stays 0 and no triggers.
3. Five clean next presses (each 10 clks low, 10 high) -> func_sel sequence 1,2,0,1,2. The wrap produces no value 3.
4. func_sel=2, ok low for 8 clks after debounce, then release -> func_hold=3'b100 during hold; trig_short=3'b100 for exactly 1 clk; trig_long never asserts; busy returns to 0.
5. func_sel=1, ok held 40 clks; toggle next cleanly during the hold -> trig_long=3'b010 for 1 clk, 17 clks after the debounced press event (16 counts + 1 registered). func_sel stays 1 and no trig_short on release.
6. Ok and next debounced press events in the same cycle -> FSM enters PRESSED with sel_lat = old func_sel, and func_sel is unchanged. Asserting rst_n=0 in PRESSED, then releasing ok, gives no trigger pulse.
